// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending-latch front end.
//   IRQ_N     : default number of request lines (priority encoder width)
//   irq_vec_t : one bit per request line
//   irq_idx_t : index of one request line
package irq_pkg;
   localparam int IRQ_N = 8;
   typedef logic [IRQ_N-1:0]         irq_vec_t;
   typedef logic [$clog2(IRQ_N)-1:0] irq_idx_t;
endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser followed by a rising-edge detector for one async line.
//   clk  : sampling clock
//   rst  : asynchronous active-high reset, clears every flop
//   d    : asynchronous input line
//   rise : one-cycle pulse when the synchronised line goes 0->1
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic [SYNC_STAGES-1:0] sync;
   logic                   s_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= '0;
         s_d  <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], d};
         s_d  <= sync[SYNC_STAGES-1];
      end
   end

   // History resets to 0, so a line already high at reset exit gives one event.
   assign rise = sync[SYNC_STAGES-1] & ~s_d;
endmodule

// File: rtl/irq_pend_latch.sv
// Sticky interrupt pending latch feeding an 8-bit priority encoder.
//   clk, rst    : clock, asynchronous active-high reset
//   irq_in      : async request lines, a 0->1 transition is one event
//   mask_we     : load mask_wdata into the mask register (bit=1 masks)
//   ack_idx     : with ack_valid, clears that pending bit (out-of-range ignored)
//   ovf_clr     : clears all overflow flags
//   pend        : raw pending bits
//   pend_masked : pend & ~mask, drives the encoder input
//   any_pend    : OR of pend_masked
//   mask        : current mask register
//   ovf         : sticky per-line overflow (event lost while already pending)
module irq_pend_latch
   import irq_pkg::*;
#(
   parameter  int N           = IRQ_N,
   parameter  int SYNC_STAGES = 2,
   localparam int IW          = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  irq_in,
   input  logic          mask_we,
   input  logic [N-1:0]  mask_wdata,
   input  logic          ack_valid,
   input  logic [IW-1:0] ack_idx,
   input  logic          ovf_clr,
   output logic [N-1:0]  pend,
   output logic [N-1:0]  pend_masked,
   output logic          any_pend,
   output logic [N-1:0]  mask,
   output logic [N-1:0]  ovf
);
   logic [N-1:0] e;
   logic [N-1:0] ack_hit;

   for (genvar i = 0; i < N; i++) begin : g_line
      sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
         .clk  (clk),
         .rst  (rst),
         .d    (irq_in[i]),
         .rise (e[i])
      );

      // An index >= N matches no line, so it is silently ignored.
      assign ack_hit[i] = ack_valid && (ack_idx == IW'(i));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            pend[i] <= 1'b0;
            ovf[i]  <= 1'b0;
         end else begin
            // A new edge beats a same-cycle ack so the event is never lost.
            pend[i] <= e[i] | (pend[i] & ~ack_hit[i]);
            // Setting beats ovf_clr; an ack in the same cycle consumes the old event.
            ovf[i]  <= (e[i] & pend[i] & ~ack_hit[i]) | (ovf[i] & ~ovf_clr);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          mask <= '0;
      else if (mask_we) mask <= mask_wdata;
   end

   // Mask only gates what the encoder sees; latching and overflow ignore it.
   assign pend_masked = pend & ~mask;
   assign any_pend    = |pend_masked;
endmodule

// File: tb/tb_irq_pend_latch.sv
module tb_irq_pend_latch;
   import irq_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   irq_vec_t   irq_in = '0, mask_wdata = '0;
   logic       mask_we = 1'b0, ack_valid = 1'b0, ovf_clr = 1'b0;
   irq_idx_t   ack_idx = '0;
   irq_vec_t   pend, pend_masked, mask, ovf;
   logic       any_pend;

   int checks = 0;
   int errors = 0;

   // Reference state: sampled history of irq_in plus the architectural registers.
   irq_vec_t samp_q[$];
   irq_vec_t m_pend, m_mask, m_ovf;

   irq_pend_latch dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
      .mask_wdata(mask_wdata), .ack_valid(ack_valid), .ack_idx(ack_idx),
      .ovf_clr(ovf_clr), .pend(pend), .pend_masked(pend_masked),
      .any_pend(any_pend), .mask(mask), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      samp_q = '{8'h00, 8'h00, 8'h00};
      m_pend = '0; m_mask = '0; m_ovf = '0;
   endfunction

   // One clock edge: an event seen at this edge is a line that was sampled
   // low three edges ago and high two edges ago.
   task automatic cycle();
      irq_vec_t ev, hit, lost;
      @(posedge clk);
      if (rst) model_reset();
      else begin
         ev   = samp_q[1] & ~samp_q[2];
         hit  = (ack_valid && int'(ack_idx) < IRQ_N) ? irq_vec_t'(1) << ack_idx : '0;
         lost = ev & m_pend & ~hit;
         m_ovf  = lost | (ovf_clr ? irq_vec_t'(0) : m_ovf);
         m_pend = ev | (m_pend & ~hit);
         if (mask_we) m_mask = mask_wdata;
         samp_q.push_front(irq_in);
         void'(samp_q.pop_back());
      end
      #1;
   endtask

   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic do_reset();
      irq_in = '0; mask_we = 0; ack_valid = 0; ovf_clr = 0;
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({pend, pend_masked, mask, ovf, any_pend} !== '0) begin
         errors++;
         $display("FAIL reset: pend=%h pm=%h mask=%h ovf=%h any=%b, all required 0",
                  pend, pend_masked, mask, ovf, any_pend);
      end
   endtask

   task automatic test_basic_latch();
      do_reset();
      irq_in = 8'h04;
      cycles(2);
      checks++;
      if (pend !== 8'h00) begin errors++; $display("FAIL latch_early: pend=%h required 00", pend); end
      cycle();
      checks++;
      if (pend !== 8'h04 || any_pend !== 1'b1) begin
         errors++; $display("FAIL latch_3clk: pend=%h any=%b required 04/1", pend, any_pend);
      end
      cycles(5);
      checks++;
      if (pend !== 8'h04 || ovf !== 8'h00) begin
         errors++; $display("FAIL latch_hold: pend=%h ovf=%h required 04/00", pend, ovf);
      end
   endtask

   task automatic test_ack_multi();
      do_reset();
      irq_in = 8'h22;
      cycles(4);
      ack_valid = 1; ack_idx = 3'd5;
      cycle();
      ack_valid = 0;
      checks++;
      if (pend !== 8'h02) begin errors++; $display("FAIL ack5: pend=%h required 02", pend); end
      ack_valid = 1; ack_idx = 3'd1;
      cycle();
      ack_valid = 0;
      checks++;
      if (pend !== 8'h00 || any_pend !== 1'b0) begin
         errors++; $display("FAIL ack1: pend=%h any=%b required 00/0", pend, any_pend);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      irq_in = 8'h08; cycles(2);
      irq_in = 8'h00; cycles(2);
      irq_in = 8'h08; cycles(4);
      checks++;
      if (pend !== 8'h08 || ovf !== 8'h08) begin
         errors++; $display("FAIL ovf_set: pend=%h ovf=%h required 08/08", pend, ovf);
      end
      ovf_clr = 1; cycle(); ovf_clr = 0;
      checks++;
      if (ovf !== 8'h00) begin errors++; $display("FAIL ovf_clr: ovf=%h required 00", ovf); end
      // Edge on bit 3 lands on the same edge as its ack.
      irq_in = 8'h00; cycles(3);
      irq_in = 8'h08; cycles(2);
      ack_valid = 1; ack_idx = 3'd3;
      cycle();
      ack_valid = 0;
      checks++;
      if (pend[3] !== 1'b1 || ovf[3] !== 1'b0) begin
         errors++; $display("FAIL edge_vs_ack: pend3=%b ovf3=%b required 1/0", pend[3], ovf[3]);
      end
   endtask

   task automatic test_mask();
      do_reset();
      mask_we = 1; mask_wdata = 8'hF0; cycle(); mask_we = 0;
      irq_in = 8'h3F; cycles(3);
      checks++;
      if (pend !== 8'h3F || pend_masked !== 8'h0F || any_pend !== 1'b1) begin
         errors++; $display("FAIL mask_f0: pend=%h pm=%h any=%b required 3f/0f/1", pend, pend_masked, any_pend);
      end
      mask_we = 1; mask_wdata = 8'hFF; cycle(); mask_we = 0;
      checks++;
      if (pend !== 8'h3F || pend_masked !== 8'h00 || any_pend !== 1'b0) begin
         errors++; $display("FAIL mask_ff: pend=%h pm=%h any=%b required 3f/00/0", pend, pend_masked, any_pend);
      end
      mask_we = 1; mask_wdata = 8'hFE; cycle(); mask_we = 0;
      checks++;
      if (pend_masked !== 8'h01) begin errors++; $display("FAIL unmask: pm=%h required 01", pend_masked); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      irq_in = 8'hA5; cycles(3);
      mask_we = 1; mask_wdata = 8'h0F; cycle(); mask_we = 0;
      irq_in = 8'hA4; cycles(2);
      irq_in = 8'hA5; cycles(3);
      checks++;
      if (pend !== 8'hA5 || mask !== 8'h0F || ovf !== 8'h01) begin
         errors++; $display("FAIL pre_rst: pend=%h mask=%h ovf=%h required a5/0f/01", pend, mask, ovf);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pend, pend_masked, mask, ovf, any_pend} !== '0) begin
         errors++; $display("FAIL async_rst: pend=%h mask=%h ovf=%h any=%b required 0", pend, mask, ovf, any_pend);
      end
      irq_in = 8'h80;
      cycle();
      rst = 1'b0;
      cycles(2);
      checks++;
      if (pend !== 8'h00) begin errors++; $display("FAIL rst_exit_early: pend=%h required 00", pend); end
      cycle();
      checks++;
      if (pend !== 8'h80) begin errors++; $display("FAIL rst_exit: pend=%h required 80", pend); end
   endtask

   // Behavioural stand-in for the downstream encoder: highest set bit wins.
   function automatic int enc_pos(input irq_vec_t v);
      enc_pos = 0;
      for (int b = 0; b < IRQ_N; b++) if (v[b]) enc_pos = b;
   endfunction

   task automatic test_encoder();
      int pos;
      do_reset();
      for (int i = 1; i < IRQ_N; i++) begin
         irq_in = irq_vec_t'(1) << i;
         cycles(3);
         pos = enc_pos(pend_masked);
         checks++;
         if (pos !== i || pend_masked !== (irq_vec_t'(1) << i)) begin
            errors++; $display("FAIL enc_pos%0d: pos=%0d pm=%h required %0d", i, pos, pend_masked, i);
         end
         ack_valid = 1; ack_idx = irq_idx_t'(pos);
         cycle();
         ack_valid = 0;
         checks++;
         if (pend !== 8'h00) begin errors++; $display("FAIL enc_ack%0d: pend=%h required 00", i, pend); end
      end
   endtask

   task automatic test_random();
      int bad = 0;
      do_reset();
      for (int t = 0; t < 400; t++) begin
         if ($urandom_range(0, 2) == 0) irq_in = irq_vec_t'($urandom);
         ack_valid  = ($urandom_range(0, 2) == 0);
         ack_idx    = irq_idx_t'($urandom);
         mask_we    = ($urandom_range(0, 9) == 0);
         mask_wdata = irq_vec_t'($urandom);
         ovf_clr    = ($urandom_range(0, 7) == 0);
         cycle();
         checks++;
         if (pend !== m_pend || mask !== m_mask || ovf !== m_ovf ||
             pend_masked !== (m_pend & ~m_mask) || any_pend !== |(m_pend & ~m_mask)) begin
            errors++;
            if (bad++ < 5)
               $display("FAIL random t=%0d: pend=%h mask=%h ovf=%h pm=%h any=%b required %h/%h/%h/%h/%b",
                        t, pend, mask, ovf, pend_masked, any_pend,
                        m_pend, m_mask, m_ovf, m_pend & ~m_mask, |(m_pend & ~m_mask));
         end
      end
      ack_valid = 0; mask_we = 0; ovf_clr = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_latch();
      test_ack_multi();
      test_overflow();
      test_mask();
      test_reset_mid();
      test_encoder();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
